// File: rtl/recon_bitstream_reader.sv
// Read-side bitstream DMA: turns one read descriptor into AXI4 read bursts and one
// AXI-stream packet, then reports a tagged completion status.
module recon_bitstream_reader #(
    parameter int DATA_WIDTH    = 64,
    parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH    = 34,
    parameter int ID_WIDTH      = 8,
    parameter int LEN_WIDTH     = 20,
    parameter int TAG_WIDTH     = 8,
    parameter int MAX_BURST_LEN = 16,
    parameter int AXI_ID        = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic [ADDR_WIDTH-1:0] s_axis_read_desc_addr,
    input  logic [LEN_WIDTH-1:0]  s_axis_read_desc_len,
    input  logic [TAG_WIDTH-1:0]  s_axis_read_desc_tag,
    input  logic                  s_axis_read_desc_valid,
    output logic                  s_axis_read_desc_ready,

    output logic [TAG_WIDTH-1:0]  m_axis_read_desc_status_tag,
    output logic [1:0]            m_axis_read_desc_status_error,
    output logic                  m_axis_read_desc_status_valid,

    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,

    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,

    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready
);

    localparam int OFF = $clog2(KEEP_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_WAIT,
        S_STATUS
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_armed;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]  r_beatsRem;
    logic [KEEP_WIDTH-1:0] r_lastKeep;
    logic [TAG_WIDTH-1:0]  r_tag;
    logic [1:0]            r_err;
    logic [8:0]            r_burst;
    logic [8:0]            r_burstCnt;

    logic [DATA_WIDTH-1:0] r_data0, r_data1;
    logic [KEEP_WIDTH-1:0] r_keep0, r_keep1;
    logic                  r_last0, r_last1;
    logic [1:0]            r_cnt;

    logic                  w_descFire;
    logic                  w_arFire;
    logic                  w_rFire;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_misaligned;
    logic [LEN_WIDTH:0]    w_lenRound;
    logic [LEN_WIDTH-1:0]  w_descBeats;
    logic [OFF-1:0]        w_lenMod;
    logic [KEEP_WIDTH-1:0] w_one;
    logic [KEEP_WIDTH-1:0] w_descKeep;
    logic [13:0]           w_toBoundary;
    logic [31:0]           w_burstWide;
    logic [8:0]            w_burst;
    logic                  w_pushLast;
    logic [KEEP_WIDTH-1:0] w_pushKeep;
    logic                  w_unused;

    assign w_descFire   = s_axis_read_desc_valid && s_axis_read_desc_ready;
    assign w_arFire     = m_axi_arvalid && m_axi_arready;
    assign w_rFire      = m_axi_rvalid && m_axi_rready;
    assign w_pop        = m_axis_tvalid && m_axis_tready;
    assign w_full       = (r_cnt == 2'd2);
    assign w_misaligned = |s_axis_read_desc_addr[OFF-1:0];

    assign w_lenRound  = {1'b0, s_axis_read_desc_len} + (LEN_WIDTH+1)'(KEEP_WIDTH - 1);
    assign w_descBeats = LEN_WIDTH'(w_lenRound >> OFF);
    assign w_lenMod    = s_axis_read_desc_len[OFF-1:0];
    assign w_one       = KEEP_WIDTH'(1);
    assign w_descKeep  = (w_lenMod == '0) ? '1 : ((w_one << w_lenMod) - w_one);

    // Burst size is the smallest of: beats left, the burst cap, and beats up to the next 4 KiB page.
    assign w_toBoundary = (14'd4096 - {2'b00, r_addr[11:0]}) >> OFF;

    always_comb begin
        w_burstWide = 32'(MAX_BURST_LEN);
        if (32'(w_toBoundary) < w_burstWide) begin
            w_burstWide = 32'(w_toBoundary);
        end
        if (32'(r_beatsRem) < w_burstWide) begin
            w_burstWide = 32'(r_beatsRem);
        end
    end

    assign w_burst    = w_burstWide[8:0];
    assign w_pushLast = (r_beatsRem == LEN_WIDTH'(1));
    assign w_pushKeep = w_pushLast ? r_lastKeep : '1;
    assign w_unused   = ^{m_axi_rid, m_axi_rlast};

    assign m_axi_arid    = ID_WIDTH'(AXI_ID);
    assign m_axi_araddr  = r_addr;
    assign m_axi_arlen   = 8'(w_burst - 9'd1);
    assign m_axi_arsize  = 3'(OFF);
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arprot  = 3'b000;

    assign m_axis_tdata  = r_data0;
    assign m_axis_tkeep  = r_keep0;
    assign m_axis_tlast  = r_last0;
    assign m_axis_tvalid = (r_cnt != 2'd0);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_descFire) begin
                    if ((s_axis_read_desc_len == '0) || w_misaligned) begin
                        w_next = S_STATUS;
                    end else begin
                        w_next = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                if (w_arFire) begin
                    w_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_rFire && (r_burstCnt == 9'd1)) begin
                    w_next = (r_beatsRem == LEN_WIDTH'(1)) ? S_WAIT : S_ADDR;
                end
            end
            S_WAIT: begin
                if ((r_cnt == 2'd0) || ((r_cnt == 2'd1) && w_pop)) begin
                    w_next = S_STATUS;
                end
            end
            S_STATUS: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // r_armed keeps the descriptor port closed while reset is held.
    assign s_axis_read_desc_ready        = (r_state == S_IDLE) && r_armed;
    assign m_axi_arvalid                 = (r_state == S_ADDR);
    assign m_axi_rready                  = (r_state == S_DATA) && !w_full;
    assign m_axis_read_desc_status_valid = (r_state == S_STATUS);
    assign m_axis_read_desc_status_tag   = m_axis_read_desc_status_valid ? r_tag : '0;
    assign m_axis_read_desc_status_error = m_axis_read_desc_status_valid ? r_err : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_armed    <= 1'b0;
            r_addr     <= '0;
            r_beatsRem <= '0;
            r_lastKeep <= '0;
            r_tag      <= '0;
            r_err      <= 2'b00;
            r_burst    <= '0;
            r_burstCnt <= '0;
        end else begin
            r_state <= w_next;
            r_armed <= 1'b1;
            if ((r_state == S_IDLE) && w_descFire) begin
                r_addr     <= s_axis_read_desc_addr;
                r_beatsRem <= w_descBeats;
                r_lastKeep <= w_descKeep;
                r_tag      <= s_axis_read_desc_tag;
                r_err      <= ((s_axis_read_desc_len != '0) && w_misaligned) ? 2'b11 : 2'b00;
            end
            if ((r_state == S_ADDR) && w_arFire) begin
                r_burst    <= w_burst;
                r_burstCnt <= w_burst;
            end
            if ((r_state == S_DATA) && w_rFire) begin
                r_beatsRem <= r_beatsRem - LEN_WIDTH'(1);
                r_burstCnt <= r_burstCnt - 9'd1;
                if ((r_err == 2'b00) && m_axi_rresp[1]) begin
                    r_err <= m_axi_rresp[0] ? 2'b10 : 2'b01;
                end
                if (r_burstCnt == 9'd1) begin
                    r_addr <= r_addr + (ADDR_WIDTH'(r_burst) << OFF);
                end
            end
        end
    end

    // Two-entry skid: entry 0 is the head driving the stream, entry 1 absorbs a stalled beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= 2'd0;
            r_data0 <= '0;
            r_data1 <= '0;
            r_keep0 <= '0;
            r_keep1 <= '0;
            r_last0 <= 1'b0;
            r_last1 <= 1'b0;
        end else begin
            if (w_rFire && w_pop) begin
                if (r_cnt == 2'd1) begin
                    r_data0 <= m_axi_rdata;
                    r_keep0 <= w_pushKeep;
                    r_last0 <= w_pushLast;
                end else begin
                    r_data0 <= r_data1;
                    r_keep0 <= r_keep1;
                    r_last0 <= r_last1;
                    r_data1 <= m_axi_rdata;
                    r_keep1 <= w_pushKeep;
                    r_last1 <= w_pushLast;
                end
            end else if (w_pop) begin
                r_data0 <= r_data1;
                r_keep0 <= r_keep1;
                r_last0 <= r_last1;
                r_cnt   <= r_cnt - 2'd1;
            end else if (w_rFire) begin
                if (r_cnt == 2'd0) begin
                    r_data0 <= m_axi_rdata;
                    r_keep0 <= w_pushKeep;
                    r_last0 <= w_pushLast;
                end else begin
                    r_data1 <= m_axi_rdata;
                    r_keep1 <= w_pushKeep;
                    r_last1 <= w_pushLast;
                end
                r_cnt <= r_cnt + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_recon_bitstream_reader.sv
// Bench for recon_bitstream_reader: table vectors, randomized descriptors against a
// descriptor-level reference model, and a mid-transfer reset sequence.
module tb_recon_bitstream_reader;

    localparam int DW = 64;
    localparam int KW = 8;
    localparam int AW = 34;
    localparam int IW = 8;
    localparam int LW = 20;
    localparam int TW = 8;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] descAddr;
    logic [LW-1:0] descLen;
    logic [TW-1:0] descTag;
    logic          descValid;
    logic          descReady;
    logic [TW-1:0] statTag;
    logic [1:0]    statErr;
    logic          statValid;
    logic [IW-1:0] arid;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic          arlock;
    logic [3:0]    arcache;
    logic [2:0]    arprot;
    logic          arvalid;
    logic          arready;
    logic [IW-1:0] rid;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rvalid;
    logic          rready;
    logic [DW-1:0] tdata;
    logic [KW-1:0] tkeep;
    logic          tlast;
    logic          tvalid;
    logic          tready;

    recon_bitstream_reader #(
        .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ADDR_WIDTH(AW), .ID_WIDTH(IW),
        .LEN_WIDTH(LW), .TAG_WIDTH(TW), .MAX_BURST_LEN(16), .AXI_ID(0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_read_desc_addr(descAddr), .s_axis_read_desc_len(descLen),
        .s_axis_read_desc_tag(descTag), .s_axis_read_desc_valid(descValid),
        .s_axis_read_desc_ready(descReady),
        .m_axis_read_desc_status_tag(statTag), .m_axis_read_desc_status_error(statErr),
        .m_axis_read_desc_status_valid(statValid),
        .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
        .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache),
        .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready),
        .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tlast(tlast),
        .m_axis_tvalid(tvalid), .m_axis_tready(tready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [7:0]    len;
    } ar_t;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    typedef struct {
        logic [AW-1:0] addr;
        int            len;
        logic [TW-1:0] tag;
        int            errBeat;
        logic [1:0]    errResp;
        int            trPct;
        int            rvPct;
        int            arPct;
        logic [1:0]    expErr;
        int            expArs;
        int            expBeats;
        int            firstArlen;
        int            lastArlen;
        int            lastKeep;
        int            thru;
    } vec_t;

    int            nAssert = 0;
    int            nFail   = 0;
    int            cycle   = 0;
    ar_t           gotAr[$];
    ar_t           expAr[$];
    beat_t         gotT[$];
    beat_t         expT[$];
    int            gotTCyc[$];
    int            statusCnt;
    logic [TW-1:0] statusTagSeen;
    logic [1:0]    statusErrSeen;
    logic [1:0]    modelErr;
    int            treadyPct  = 100;
    int            rvalidPct  = 100;
    int            arreadyPct = 100;
    logic [AW-1:0] errAddr;
    logic [1:0]    errResp;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        nAssert++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] memWord(input logic [AW-1:0] a);
        return {a[31:0] * 32'h9E37_79B1, a[33:2] ^ 32'h5A5A_5A5A};
    endfunction

    // Descriptor-level reference: byte count -> beats, 4 KiB / 16-beat chunking, error mapping.
    task automatic buildModel(input logic [AW-1:0] addr, input int len, input int errBeat,
                              input logic [1:0] eResp);
        int            n;
        int            rem;
        int            b;
        int            bound;
        logic [AW-1:0] a;
        beat_t         bt;
        expAr.delete();
        expT.delete();
        modelErr = 2'b00;
        if (len == 0) begin
            modelErr = 2'b00;
        end else if (addr % 8 != 0) begin
            modelErr = 2'b11;
        end else begin
            n   = (len + 7) / 8;
            rem = n;
            a   = addr;
            while (rem > 0) begin
                bound = (4096 - int'(a % 4096)) / 8;
                b = rem;
                if (b > 16) b = 16;
                if (b > bound) b = bound;
                expAr.push_back('{a, 8'(b - 1)});
                a   = a + AW'(b * 8);
                rem = rem - b;
            end
            for (int i = 0; i < n; i++) begin
                bt.d = memWord(addr + AW'(i * 8));
                bt.k = ((i == n - 1) && (len % 8 != 0)) ? 8'((1 << (len % 8)) - 1) : 8'hFF;
                bt.l = (i == n - 1);
                expT.push_back(bt);
            end
            if (errBeat >= 0 && errBeat < n && eResp[1]) begin
                modelErr = (eResp == 2'b10) ? 2'b01 : 2'b10;
            end
        end
    endtask

    // Memory slave, stream sink and monitors: sample at negedge, drive 1 after posedge.
    ar_t           slvQ[$];
    ar_t           slvCur;
    logic          slvActive = 1'b0;
    int            slvBeat;
    logic          hsAr, hsR, hsT;
    logic          prevTStall = 1'b0;
    logic          prevArStall = 1'b0;
    beat_t         prevBeat;
    ar_t           prevAr;
    logic [AW-1:0] ra;

    initial begin
        arready = 1'b0;
        rvalid  = 1'b0;
        rdata   = '0;
        rresp   = 2'b00;
        rlast   = 1'b0;
        rid     = '0;
        tready  = 1'b0;
        forever begin
            @(negedge clk);
            cycle++;
            hsAr = rst_n && arvalid && arready;
            hsR  = rst_n && rvalid && rready;
            hsT  = rst_n && tvalid && tready;
            if (rst_n && prevTStall) begin
                chk("t_stable", {tvalid, tdata, tkeep, tlast}, {1'b1, prevBeat});
            end
            if (rst_n && prevArStall) begin
                chk("ar_stable", {arvalid, araddr, arlen}, {1'b1, prevAr});
            end
            prevTStall  = rst_n && tvalid && !tready;
            prevBeat    = '{tdata, tkeep, tlast};
            prevArStall = rst_n && arvalid && !arready;
            prevAr      = '{araddr, arlen};
            if (hsAr) begin
                gotAr.push_back('{araddr, arlen});
                chk("ar_const", {arid, arsize, arburst, arlock, arcache, arprot},
                    {8'h00, 3'd3, 2'b01, 1'b0, 4'b0011, 3'b000});
            end
            if (hsT) begin
                gotT.push_back('{tdata, tkeep, tlast});
                gotTCyc.push_back(cycle);
            end
            if (rst_n && statValid) begin
                statusCnt++;
                statusTagSeen = statTag;
                statusErrSeen = statErr;
            end
            @(posedge clk);
            #1;
            if (!rst_n) begin
                slvQ.delete();
                slvActive = 1'b0;
                rvalid    = 1'b0;
                arready   = 1'b0;
                tready    = 1'b0;
                continue;
            end
            if (hsAr) slvQ.push_back(gotAr[gotAr.size() - 1]);
            if (hsR) begin
                slvBeat++;
                if (slvBeat > int'(slvCur.len)) slvActive = 1'b0;
            end
            if (!slvActive && slvQ.size() > 0) begin
                slvCur    = slvQ.pop_front();
                slvBeat   = 0;
                slvActive = 1'b1;
            end
            if (!(rvalid && !hsR)) begin
                if (slvActive && ($urandom_range(0, 99) < rvalidPct)) begin
                    ra     = slvCur.a + AW'(slvBeat * 8);
                    rvalid = 1'b1;
                    rdata  = memWord(ra);
                    rresp  = (ra == errAddr) ? errResp : 2'b00;
                    rlast  = (slvBeat == int'(slvCur.len));
                end else begin
                    rvalid = 1'b0;
                end
            end
            arready = ($urandom_range(0, 99) < arreadyPct);
            tready  = ($urandom_range(0, 99) < treadyPct);
        end
    end

    task automatic sendDesc(input logic [AW-1:0] addr, input int len, input logic [TW-1:0] tag);
        int   waited = 0;
        logic accepted = 1'b0;
        @(posedge clk);
        #1;
        descAddr  = addr;
        descLen   = LW'(len);
        descTag   = tag;
        descValid = 1'b1;
        while (!accepted && waited < 200) begin
            @(negedge clk);
            accepted = descReady;
            @(posedge clk);
            #1;
            waited++;
        end
        descValid = 1'b0;
        chk("desc_accepted", accepted, 1'b1);
    endtask

    task automatic applyStimulus(input logic [AW-1:0] addr, input int len, input logic [TW-1:0] tag,
                                 input int errBeat, input logic [1:0] eResp,
                                 input int tr, input int rv, input int ar);
        int waited = 0;
        treadyPct  = tr;
        rvalidPct  = rv;
        arreadyPct = ar;
        errAddr    = (errBeat >= 0) ? addr + AW'(errBeat * 8) : '1;
        errResp    = eResp;
        buildModel(addr, len, errBeat, eResp);
        gotAr.delete();
        gotT.delete();
        gotTCyc.delete();
        statusCnt = 0;
        sendDesc(addr, len, tag);
        while (statusCnt == 0 && waited < 20000) begin
            @(posedge clk);
            waited++;
        end
        repeat (4) @(posedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [TW-1:0] tag);
        int idx;
        chk({name, "_pulses"}, statusCnt, 1);
        chk({name, "_tag"}, statusTagSeen, tag);
        chk({name, "_err"}, statusErrSeen, modelErr);
        chk({name, "_ar_count"}, gotAr.size(), expAr.size());
        chk({name, "_beat_count"}, gotT.size(), expT.size());
        if (gotAr.size() == expAr.size() && expAr.size() > 0) begin
            idx = expAr.size() - 1;
            for (int i = expAr.size() - 1; i >= 0; i--) if (gotAr[i] !== expAr[i]) idx = i;
            chk({name, "_ar_list"}, gotAr[idx], expAr[idx]);
        end
        if (gotT.size() == expT.size() && expT.size() > 0) begin
            idx = expT.size() - 1;
            for (int i = expT.size() - 1; i >= 0; i--) if (gotT[i] !== expT[i]) idx = i;
            chk({name, "_stream"}, gotT[idx], expT[idx]);
        end
    endtask

    task automatic checkIdleOutputs(input string name);
        chk({name, "_valids"}, {descReady, arvalid, rready, tvalid, statValid}, 5'b0);
        chk({name, "_status"}, {statTag, statErr}, 10'b0);
    endtask

    vec_t vecs[8];

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int            nl;
        int            tl;
        logic [AW-1:0] ra2;
        int            rl;
        int            eb;
        int            waited;
        string         nm;

        vecs[0] = '{34'h1000, 64, 8'h11, -1, 2'b00, 100, 100, 100, 2'b00, 1, 8, 7, 7, 'hFF, 1};
        vecs[1] = '{34'h0000, 1029, 8'h22, -1, 2'b00, 100, 100, 100, 2'b00, 9, 129, 15, 0, 'h1F, 0};
        vecs[2] = '{34'h0FF0, 64, 8'h33, -1, 2'b00, 100, 100, 100, 2'b00, 2, 8, 1, 5, 'hFF, 0};
        vecs[3] = '{34'h0040, 0, 8'h44, -1, 2'b00, 100, 100, 100, 2'b00, 0, 0, -1, -1, -1, 0};
        vecs[4] = '{34'h1003, 16, 8'h55, -1, 2'b00, 100, 100, 100, 2'b11, 0, 0, -1, -1, -1, 0};
        vecs[5] = '{34'h2000, 64, 8'h66, 2, 2'b10, 50, 70, 50, 2'b01, 1, 8, 7, 7, 'hFF, 0};
        vecs[6] = '{34'h3000, 20, 8'h77, 1, 2'b11, 60, 80, 60, 2'b10, 1, 3, 2, 2, 'h0F, 0};
        vecs[7] = '{34'h1FE8, 200, 8'h88, -1, 2'b00, 70, 90, 80, 2'b00, 3, 25, 2, 5, 'hFF, 0};

        rst_n     = 1'b0;
        descAddr  = '0;
        descLen   = '0;
        descTag   = '0;
        descValid = 1'b0;
        errAddr   = '1;
        errResp   = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        checkIdleOutputs("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 8; i++) begin
            nm = $sformatf("vec%0d", i);
            applyStimulus(vecs[i].addr, vecs[i].len, vecs[i].tag, vecs[i].errBeat, vecs[i].errResp,
                          vecs[i].trPct, vecs[i].rvPct, vecs[i].arPct);
            checkOutput(nm, vecs[i].tag);
            chk({nm, "_tbl_err"}, statusErrSeen, vecs[i].expErr);
            chk({nm, "_tbl_ars"}, gotAr.size(), vecs[i].expArs);
            chk({nm, "_tbl_beats"}, gotT.size(), vecs[i].expBeats);
            tl = 0;
            foreach (gotT[j]) if (gotT[j].l) tl++;
            chk({nm, "_tlast_count"}, tl, (vecs[i].expBeats > 0) ? 1 : 0);
            if (vecs[i].firstArlen >= 0 && gotAr.size() > 0) begin
                chk({nm, "_first_arlen"}, gotAr[0].len, vecs[i].firstArlen);
                chk({nm, "_last_arlen"}, gotAr[gotAr.size() - 1].len, vecs[i].lastArlen);
            end
            if (vecs[i].lastKeep >= 0 && gotT.size() > 0) begin
                chk({nm, "_last_keep"}, gotT[gotT.size() - 1].k, vecs[i].lastKeep);
            end
            if (vecs[i].thru != 0 && gotTCyc.size() > 0) begin
                chk({nm, "_throughput"}, gotTCyc[gotTCyc.size() - 1] - gotTCyc[0],
                    vecs[i].expBeats - 1);
            end
        end

        for (int i = 0; i < 25; i++) begin
            ra2 = AW'($urandom_range(0, 7) * 4096 + $urandom_range(0, 511) * 8);
            if ($urandom_range(0, 9) == 0) ra2 = ra2 + AW'($urandom_range(1, 7));
            rl = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 400));
            nl = (rl + 7) / 8;
            eb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, nl)) : -1;
            applyStimulus(ra2, rl, 8'($urandom), eb, 2'($urandom_range(1, 3)),
                          int'($urandom_range(30, 100)), int'($urandom_range(40, 100)),
                          int'($urandom_range(30, 100)));
            checkOutput($sformatf("rand%0d", i), descTag);
        end

        treadyPct  = 100;
        rvalidPct  = 100;
        arreadyPct = 100;
        errAddr    = '1;
        gotT.delete();
        sendDesc(34'h0, 1029, 8'h99);
        waited = 0;
        while (gotT.size() < 5 && waited < 500) begin
            @(posedge clk);
            waited++;
        end
        chk("midrst_reached_data", (gotT.size() >= 5), 1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkIdleOutputs("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        applyStimulus(34'h5000, 40, 8'hAB, -1, 2'b00, 80, 90, 90);
        checkOutput("after_reset", 8'hAB);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
